// File: rtl/load_store_unit_pkg.sv
// Shared codes for the load/store unit: opcodes, FSM states and small
// opcode-classification helpers used by the controller and lane logic.
package load_store_unit_pkg;

  // Four-bit opcode space leaves room for encodings that are not listed;
  // those are ignored by the controller.
  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  function automatic logic op_is_valid(input opcode_t op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input opcode_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Words need offset 0; halves need an even offset; bytes never fault.
  function automatic logic op_misaligned(input opcode_t op, input logic [1:0] offset);
    case (op)
      OP_LW, OP_SW:         return offset != 2'b00;
      OP_LH, OP_LHU, OP_SH: return offset[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Avalon-MM master bus between the load/store unit and memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] avm_address_o;
  logic              avm_read_o;
  logic              avm_write_o;
  logic [31:0]       avm_writedata_o;
  logic [3:0]        avm_byteenable_o;
  logic [31:0]       avm_readdata_i;
  logic              avm_waitrequest_i;

  modport master (
    output avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
    input  avm_readdata_i, avm_waitrequest_i
  );

  modport slave (
    input  avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
    output avm_readdata_i, avm_waitrequest_i
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian byte-lane steering: byte enables and store replication on
// the way out, lane select plus sign/zero extension on the way back.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  opcode_t     opcode_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] readdata_i,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  half_be;
  logic [3:0]  byte_be;

  assign lane_byte = readdata_i[{offset_i, 3'b000} +: 8];
  assign lane_half = offset_i[1] ? readdata_i[31:16] : readdata_i[15:0];
  assign half_be   = offset_i[1] ? 4'b1100 : 4'b0011;
  assign byte_be   = 4'b0001 << offset_i;

  // Per-opcode lane mapping; unlisted opcodes produce all zeros.
  always_comb begin
    byteenable_o = 4'b0000;
    writedata_o  = 32'h0;
    load_data_o  = 32'h0;
    case (opcode_i)
      OP_LW: begin
        byteenable_o = 4'b1111;
        load_data_o  = readdata_i;
      end
      OP_LH: begin
        byteenable_o = half_be;
        load_data_o  = {{16{lane_half[15]}}, lane_half};
      end
      OP_LHU: begin
        byteenable_o = half_be;
        load_data_o  = {16'h0, lane_half};
      end
      OP_LB: begin
        byteenable_o = byte_be;
        load_data_o  = {{24{lane_byte[7]}}, lane_byte};
      end
      OP_LBU: begin
        byteenable_o = byte_be;
        load_data_o  = {24'h0, lane_byte};
      end
      OP_SW: begin
        byteenable_o = 4'b1111;
        writedata_o  = store_data_i;
      end
      OP_SH: begin
        byteenable_o = half_be;
        writedata_o  = {2{store_data_i[15:0]}};
      end
      OP_SB: begin
        byteenable_o = byte_be;
        writedata_o  = {4{store_data_i[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller driving an Avalon-MM master.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start_i; bus quiet, all outputs low
// ST_ACCESS | one read or write command held until waitrequest drops
// ST_DONE   | one-cycle done_o pulse carrying load data / error flag
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        addr_error_o,
  load_store_unit_if.master avm
);

  lsu_state_t        state_q, state_d;
  opcode_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              err_q, err_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic        in_access;
  logic        is_store;

  lsu_lane_align u_lane_align (
    .opcode_i     (op_q),
    .offset_i     (addr_q[1:0]),
    .store_data_i (sdata_q),
    .readdata_i   (avm.avm_readdata_i),
    .byteenable_o (lane_be),
    .writedata_o  (lane_wdata),
    .load_data_o  (lane_load)
  );

  // State and latched request; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      sdata_q <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE only, misaligned requests skip the bus.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && op_is_valid(opcode_i)) begin
          op_d    = opcode_i;
          addr_d  = effective_address_i[ADDR_W-1:0];
          sdata_d = store_data_i;
          ldata_d = '0;
          if (op_misaligned(opcode_i, effective_address_i[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!avm.avm_waitrequest_i) begin
          ldata_d = op_is_store(op_q) ? 32'h0 : lane_load;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ldata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_access = (state_q == ST_ACCESS);
  assign is_store  = op_is_store(op_q);

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign load_data_o  = done_o ? ldata_q : 32'h0;
  assign addr_error_o = done_o & err_q;

  // Bus fields come straight from registers, so they hold during waitrequest.
  assign avm.avm_read_o       = in_access & ~is_store;
  assign avm.avm_write_o      = in_access & is_store;
  assign avm.avm_address_o    = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign avm.avm_byteenable_o = in_access ? lane_be : 4'b0000;
  assign avm.avm_writedata_o  = (in_access && is_store) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned/misaligned loads and stores,
// waitrequest stalls, ignored start pulses and reset behaviour.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  opcode_t     opcode;
  logic [31:0] eff_addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        addr_error;

  int n_pass  = 0;
  int n_total = 0;

  load_store_unit_if #(.ADDR_W(32)) avm_if ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk                 (clk),
    .reset_n_i           (reset_n),
    .start_i             (start),
    .opcode_i            (opcode),
    .effective_address_i (eff_addr),
    .store_data_i        (store_data),
    .busy_o              (busy),
    .done_o              (done),
    .load_data_o         (load_data),
    .addr_error_o        (addr_error),
    .avm                 (avm_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input opcode_t op, input logic [31:0] a, input logic [31:0] sd);
    start      = 1'b1;
    opcode     = op;
    eff_addr   = a;
    store_data = sd;
  endtask

  // Checks the bus during one ACCESS cycle.
  task automatic check_bus(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    check({tag, ".read"},  {31'h0, avm_if.avm_read_o},      {31'h0, rd});
    check({tag, ".write"}, {31'h0, avm_if.avm_write_o},     {31'h0, wr});
    check({tag, ".addr"},  avm_if.avm_address_o,            a);
    check({tag, ".be"},    {28'h0, avm_if.avm_byteenable_o}, {28'h0, be});
    check({tag, ".wdata"}, avm_if.avm_writedata_o,          wd);
    check({tag, ".done"},  {31'h0, done},                    32'h0);
  endtask

  task automatic check_done(input string tag, input logic [31:0] ld, input logic err);
    check({tag, ".done"},  {31'h0, done},       32'h1);
    check({tag, ".ld"},    load_data,           ld);
    check({tag, ".err"},   {31'h0, addr_error}, {31'h0, err});
    check({tag, ".rw"},    {30'h0, avm_if.avm_read_o, avm_if.avm_write_o}, 32'h0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, {31'h0, busy}, 32'h0);
    check({tag, ".done"}, {31'h0, done}, 32'h0);
    check({tag, ".rw"},   {30'h0, avm_if.avm_read_o, avm_if.avm_write_o}, 32'h0);
    check({tag, ".addr"}, avm_if.avm_address_o, 32'h0);
  endtask

  // One request with zero wait states: accept, ACCESS, DONE, IDLE.
  task automatic run_simple(input string tag, input opcode_t op, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rdata,
                            input logic rd, input logic wr, input logic [31:0] wa,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ld);
    req(op, a, sd);
    avm_if.avm_readdata_i    = rdata;
    avm_if.avm_waitrequest_i = 1'b0;
    tick();
    start = 1'b0;
    check({tag, ".busy"}, {31'h0, busy}, 32'h1);
    check_bus(tag, rd, wr, wa, be, wd);
    tick();
    check_done(tag, ld, 1'b0);
    tick();
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    opcode     = OP_LW;
    eff_addr   = 32'h0;
    store_data = 32'h0;
    avm_if.avm_readdata_i    = 32'h0;
    avm_if.avm_waitrequest_i = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset.ld", load_data, 32'h0);
    reset_n = 1'b1;
    tick();

    // Zero-wait loads and stores covering every lane mapping.
    run_simple("lw",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_simple("lbu", OP_LBU, 32'h103, 32'h0, 32'h80112233, 1, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
    run_simple("lh",  OP_LH,  32'h102, 32'h0, 32'h80112233, 1, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8011);
    run_simple("lhu", OP_LHU, 32'h100, 32'h0, 32'h80112233, 1, 0, 32'h100, 4'b0011, 32'h0, 32'h00002233);
    run_simple("lb1", OP_LB,  32'h101, 32'h0, 32'h80112233, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h00000022);
    run_simple("sh",  OP_SH,  32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    run_simple("sb",  OP_SB,  32'h101, 32'h12345677, 32'hFFFFFFFF, 0, 1, 32'h100, 4'b0010, 32'h77777777, 32'h0);
    run_simple("sw",  OP_SW,  32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h0);

    // LB with three stalled cycles; fields must hold steady.
    req(OP_LB, 32'h103, 32'h0);
    avm_if.avm_readdata_i    = 32'h80112233;
    avm_if.avm_waitrequest_i = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bus($sformatf("lbwait%0d", i), 1, 0, 32'h100, 4'b1000, 32'h0);
      if (i == 2) avm_if.avm_waitrequest_i = 1'b0;
      tick();
    end
    check_done("lbwait", 32'hFFFFFF80, 1'b0);
    tick();
    check_idle("lbwait.after");

    // Misaligned requests finish the next cycle without a bus command.
    req(OP_LH, 32'h101, 32'h0);
    avm_if.avm_readdata_i = 32'h12345678;
    tick();
    start = 1'b0;
    check_done("lhmis", 32'h0, 1'b1);
    check("lhmis.busy", {31'h0, busy}, 32'h1);
    tick();
    check_idle("lhmis.after");
    check("lhmis.err_clr", {31'h0, addr_error}, 32'h0);

    req(OP_SW, 32'h102, 32'h55AA55AA);
    tick();
    start = 1'b0;
    check_done("swmis", 32'h0, 1'b1);
    tick();
    check_idle("swmis.after");

    // Unlisted opcode is ignored.
    req(opcode_t'(4'h3), 32'h100, 32'h0);
    tick();
    start = 1'b0;
    check_idle("badop");

    // start held during ACCESS: one command only, second request dropped.
    req(OP_LW, 32'h300, 32'h0);
    avm_if.avm_readdata_i    = 32'h01020304;
    avm_if.avm_waitrequest_i = 1'b1;
    tick();
    req(OP_SW, 32'h400, 32'hFFFFFFFF);
    check_bus("busy0", 1, 0, 32'h300, 4'b1111, 32'h0);
    tick();
    check_bus("busy1", 1, 0, 32'h300, 4'b1111, 32'h0);
    start = 1'b0;
    avm_if.avm_waitrequest_i = 1'b0;
    tick();
    check_done("busy", 32'h01020304, 1'b0);
    tick();
    check_idle("busy.after");

    // Reset in the middle of a stalled read drops the command.
    req(OP_LW, 32'h500, 32'h0);
    avm_if.avm_waitrequest_i = 1'b1;
    tick();
    start = 1'b0;
    check_bus("rstmid", 1, 0, 32'h500, 4'b1111, 32'h0);
    reset_n = 1'b0;
    tick();
    check_idle("rstmid.after");
    check("rstmid.be", {28'h0, avm_if.avm_byteenable_o}, 32'h0);
    reset_n = 1'b1;
    avm_if.avm_waitrequest_i = 1'b0;
    tick();

    // Reset wins over start in the same cycle.
    req(OP_LW, 32'h100, 32'h0);
    reset_n = 1'b0;
    tick();
    start   = 1'b0;
    reset_n = 1'b1;
    check_idle("rststart");
    tick();
    check_idle("rststart.after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
